// File: rtl/axis_rule_classifier_if.sv
// AXI-Stream beat bundle with tuser sideband fields.
// The master modport drives the beat; the slave modport drives tready.
interface axis_rule_classifier_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [15:0]           tuser_size;
  logic [15:0]           tuser_src;
  logic [15:0]           tuser_dst;

  modport master (
    output tvalid, tdata, tkeep, tlast,
    output tuser_size, tuser_src, tuser_dst,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast,
    input  tuser_size, tuser_src, tuser_dst,
    output tready
  );
endinterface

// File: rtl/axis_rule_classifier.sv
// Single-stage AXI-Stream packet classifier with a src/dst mask rule table.
// Define AXIS_RULE_CLASSIFIER_HITCNT_EN to add per-rule hit counters.
module axis_rule_classifier #(
  parameter int DATA_WIDTH    = 512,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int NUM_RULES     = 8,
  parameter int DEFAULT_ALLOW = 1,
  localparam int IDX_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axis_rule_classifier_if.slave    s_axis,
  axis_rule_classifier_if.master   m_axis,
  output logic                     decision_valid,
  output logic                     decision_allow,
  input  logic                     cfg_wr_en,
  input  logic [IDX_W-1:0]         cfg_wr_idx,
  input  logic [65:0]              cfg_wr_rule,
  output logic [31:0]              cnt_pkts,
  output logic [31:0]              cnt_allow,
  output logic [31:0]              cnt_deny,
  input  logic [IDX_W-1:0]         cfg_rd_idx,
  output logic [31:0]              cfg_rd_hits
);

  typedef enum logic {HEAD, BODY} state_e;

  state_e                state_q;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [KEEP_WIDTH-1:0] m_keep_q;
  logic                  m_last_q;
  logic [15:0]           m_size_q;
  logic [15:0]           m_src_q;
  logic [15:0]           m_dst_q;
  logic                  head_q;
  logic                  verdict_q;
  logic [31:0]           pkts_q;
  logic [31:0]           allow_q;
  logic [31:0]           deny_q;
  logic [65:0]           rules_q [NUM_RULES];

  logic                  s_ready;
  logic                  accept;
  logic                  head_acc;
  logic                  wr_ok;
  logic                  hit;
  logic                  hit_allow;
  logic [IDX_W-1:0]      sel;
  logic                  verdict_d;

  // Rule layout: {en, allow, src_val, src_mask, dst_val, dst_mask}
  function automatic logic rule_match(
    input logic [65:0] r,
    input logic [15:0] src,
    input logic [15:0] dst
  );
    return r[65]
      && ((src & r[47:32]) == (r[63:48] & r[47:32]))
      && ((dst & r[15:0]) == (r[31:16] & r[15:0]));
  endfunction

  assign s_ready  = !m_valid_q || m_axis.tready;
  assign accept   = s_axis.tvalid && s_ready;
  assign head_acc = accept && (state_q == HEAD);
  assign wr_ok    = cfg_wr_en && (32'(cfg_wr_idx) < NUM_RULES);

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit       = 1'b0;
    hit_allow = 1'b0;
    sel       = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (rule_match(rules_q[i], s_axis.tuser_src, s_axis.tuser_dst)) begin
        hit       = 1'b1;
        hit_allow = rules_q[i][64];
        sel       = IDX_W'(i);
      end
    end
    verdict_d = hit ? hit_allow : (DEFAULT_ALLOW != 0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HEAD;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_size_q  <= '0;
      m_src_q   <= '0;
      m_dst_q   <= '0;
      head_q    <= 1'b0;
      verdict_q <= 1'b0;
      pkts_q    <= '0;
      allow_q   <= '0;
      deny_q    <= '0;
      for (int i = 0; i < NUM_RULES; i++) rules_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RULES; i++) begin
        if (wr_ok && cfg_wr_idx == IDX_W'(i)) rules_q[i] <= cfg_wr_rule;
      end
      if (accept) begin
        m_valid_q <= 1'b1;
        m_data_q  <= s_axis.tdata;
        m_keep_q  <= s_axis.tkeep;
        m_last_q  <= s_axis.tlast;
        m_size_q  <= s_axis.tuser_size;
        m_src_q   <= s_axis.tuser_src;
        m_dst_q   <= s_axis.tuser_dst;
        head_q    <= (state_q == HEAD);
        verdict_q <= (state_q == HEAD) && verdict_d;
        unique case (state_q)
          HEAD: if (!s_axis.tlast) state_q <= BODY;
          BODY: if (s_axis.tlast) state_q <= HEAD;
        endcase
        if (head_acc) begin
          pkts_q <= pkts_q + 32'd1;
          if (verdict_d) allow_q <= allow_q + 32'd1;
          else           deny_q  <= deny_q + 32'd1;
        end
      end else if (m_axis.tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign s_axis.tready     = s_ready;
  assign m_axis.tvalid     = m_valid_q;
  assign m_axis.tdata      = m_data_q;
  assign m_axis.tkeep      = m_keep_q;
  assign m_axis.tlast      = m_last_q;
  assign m_axis.tuser_size = m_size_q;
  assign m_axis.tuser_src  = m_src_q;
  assign m_axis.tuser_dst  = m_dst_q;
  assign decision_valid    = m_valid_q && head_q;
  assign decision_allow    = decision_valid && verdict_q;
  assign cnt_pkts          = pkts_q;
  assign cnt_allow         = allow_q;
  assign cnt_deny          = deny_q;

`ifdef AXIS_RULE_CLASSIFIER_HITCNT_EN
  logic [31:0] hits_q [NUM_RULES];
  logic [31:0] rd_q;

  // A rewrite clears the counter even if that rule hits the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      for (int i = 0; i < NUM_RULES; i++) hits_q[i] <= '0;
    end else begin
      rd_q <= '0;
      for (int i = 0; i < NUM_RULES; i++) begin
        if (wr_ok && cfg_wr_idx == IDX_W'(i)) begin
          hits_q[i] <= '0;
        end else if (head_acc && hit && sel == IDX_W'(i)) begin
          hits_q[i] <= hits_q[i] + 32'd1;
        end
        if (cfg_rd_idx == IDX_W'(i)) rd_q <= hits_q[i];
      end
    end
  end

  assign cfg_rd_hits = rd_q;
`else
  logic unused_hitcnt;
  assign unused_hitcnt = ^{cfg_rd_idx, sel};
  assign cfg_rd_hits   = '0;
`endif

endmodule

// File: tb/tb_axis_rule_classifier.sv
// Directed testbench for axis_rule_classifier.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_axis_rule_classifier;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int NR = 6;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_rule_classifier_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_if ();
  axis_rule_classifier_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_if ();

  logic          cfg_wr_en;
  logic [IW-1:0] cfg_wr_idx;
  logic [65:0]   cfg_wr_rule;
  logic [IW-1:0] cfg_rd_idx;
  logic          dv, da;
  logic [31:0]   cp, ca, cd, hits;
  int            tests = 0;
  int            fails = 0;

  axis_rule_classifier #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
    .NUM_RULES(NR), .DEFAULT_ALLOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis(s_if), .m_axis(m_if),
    .decision_valid(dv), .decision_allow(da),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx),
    .cfg_wr_rule(cfg_wr_rule),
    .cnt_pkts(cp), .cnt_allow(ca), .cnt_deny(cd),
    .cfg_rd_idx(cfg_rd_idx), .cfg_rd_hits(hits)
  );

  task automatic beat(input logic [63:0] d, input logic last,
                      input logic [15:0] src);
    s_if.tvalid     = 1'b1;
    s_if.tdata      = d;
    s_if.tkeep      = 8'hF0;
    s_if.tlast      = last;
    s_if.tuser_size = d[15:0];
    s_if.tuser_src  = src;
    s_if.tuser_dst  = 16'h0000;
    @(negedge clk);
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_rule(input logic [IW-1:0] idx, input logic [65:0] r);
    cfg_wr_en   = 1'b1;
    cfg_wr_idx  = idx;
    cfg_wr_rule = r;
    @(negedge clk);
    cfg_wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    s_if.tuser_size = '0; s_if.tuser_src = '0; s_if.tuser_dst = '0;
    m_if.tready = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_rule = '0; cfg_rd_idx = '0;
    repeat (2) @(negedge clk);
    tests++; if (m_if.tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got %b want 0", m_if.tvalid); end
    tests++; if (dv !== 1'b0) begin fails++; $display("FAIL rst_dv got %b want 0", dv); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (s_if.tready !== 1'b1) begin fails++; $display("FAIL rst_sready got %b want 1", s_if.tready); end
    tests++; if ({cp, ca, cd} !== 96'h0) begin fails++; $display("FAIL rst_cnt got %h want 0", {cp, ca, cd}); end
    tests++; if (hits !== 32'h0) begin fails++; $display("FAIL rst_hits got %h want 0", hits); end
  endtask

  task automatic test_default();
    beat(64'h11, 1'b0, 16'h0001);
    tests++; if (m_if.tvalid !== 1'b1) begin fails++; $display("FAIL def_tvalid got %b want 1", m_if.tvalid); end
    tests++; if (m_if.tdata !== 64'h11) begin fails++; $display("FAIL def_tdata got %h want 11", m_if.tdata); end
    tests++; if (m_if.tkeep !== 8'hF0) begin fails++; $display("FAIL def_tkeep got %h want f0", m_if.tkeep); end
    tests++; if (m_if.tuser_size !== 16'h11 || m_if.tuser_src !== 16'h1) begin
      fails++; $display("FAIL def_tuser got %h/%h want 0011/0001", m_if.tuser_size, m_if.tuser_src); end
    tests++; if ({dv, da} !== 2'b11) begin fails++; $display("FAIL def_head got %b want 11", {dv, da}); end
    beat(64'h22, 1'b0, 16'h0001);
    tests++; if (m_if.tdata !== 64'h22) begin fails++; $display("FAIL def_b1 got %h want 22", m_if.tdata); end
    tests++; if ({dv, da} !== 2'b00) begin fails++; $display("FAIL def_body got %b want 00", {dv, da}); end
    beat(64'h33, 1'b1, 16'h0001);
    tests++; if (m_if.tlast !== 1'b1 || dv !== 1'b0) begin
      fails++; $display("FAIL def_last got %b/%b want 1/0", m_if.tlast, dv); end
    idle();
    tests++; if (m_if.tvalid !== 1'b0) begin fails++; $display("FAIL def_drain got %b want 0", m_if.tvalid); end
    tests++; if ({cp, ca, cd} !== {32'd1, 32'd1, 32'd0}) begin
      fails++; $display("FAIL def_cnt got %0d/%0d/%0d want 1/1/0", cp, ca, cd); end
  endtask

  task automatic test_ignored_idx();
    wr_rule(3'd7, {1'b1, 1'b0, 64'h0});
    beat(64'h44, 1'b1, 16'h0A55);
    tests++; if ({dv, da} !== 2'b11) begin fails++; $display("FAIL ign_idx got %b want 11", {dv, da}); end
    idle();
  endtask

  task automatic test_rules();
    wr_rule(3'd0, {1'b1, 1'b0, 16'h0A00, 16'hFF00, 32'h0});
    wr_rule(3'd1, {1'b1, 1'b1, 64'h0});
    beat(64'h55, 1'b1, 16'h0A55);
    tests++; if ({dv, da} !== 2'b10) begin fails++; $display("FAIL rule_0a55 got %b want 10", {dv, da}); end
    beat(64'h66, 1'b1, 16'h0B00);
    tests++; if ({dv, da} !== 2'b11) begin fails++; $display("FAIL rule_0b00 got %b want 11", {dv, da}); end
    idle();
    tests++; if ({cp, ca, cd} !== {32'd4, 32'd3, 32'd1}) begin
      fails++; $display("FAIL rule_cnt got %0d/%0d/%0d want 4/3/1", cp, ca, cd); end
  endtask

  task automatic test_backpressure();
    beat(64'h70, 1'b0, 16'h0A10);
    tests++; if ({dv, da} !== 2'b10) begin fails++; $display("FAIL bp_head got %b want 10", {dv, da}); end
    m_if.tready = 1'b0;
    s_if.tdata = 64'h71; s_if.tuser_size = 16'h71;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== 64'h70 || {dv, da} !== 2'b10 || s_if.tready !== 1'b0) begin
        fails++; $display("FAIL bp_hold%0d got v=%b d=%h dec=%b rdy=%b want 1/70/10/0",
                          i, m_if.tvalid, m_if.tdata, {dv, da}, s_if.tready); end
    end
    m_if.tready = 1'b1;
    @(negedge clk);
    tests++; if (m_if.tdata !== 64'h71 || dv !== 1'b0) begin
      fails++; $display("FAIL bp_b1 got %h/%b want 71/0", m_if.tdata, dv); end
    beat(64'h72, 1'b1, 16'h0A10);
    tests++; if (m_if.tdata !== 64'h72 || m_if.tlast !== 1'b1) begin
      fails++; $display("FAIL bp_b2 got %h/%b want 72/1", m_if.tdata, m_if.tlast); end
    idle();
    tests++; if (m_if.tvalid !== 1'b0 || {cp, ca, cd} !== {32'd5, 32'd3, 32'd2}) begin
      fails++; $display("FAIL bp_end got v=%b %0d/%0d/%0d want 0 5/3/2", m_if.tvalid, cp, ca, cd); end
  endtask

  task automatic test_cfg_race();
    cfg_wr_en = 1'b1; cfg_wr_idx = 3'd0;
    cfg_wr_rule = {1'b1, 1'b1, 16'h0A00, 16'hFF00, 32'h0};
    beat(64'h80, 1'b1, 16'h0A01);
    cfg_wr_en = 1'b0;
    tests++; if ({dv, da} !== 2'b10) begin fails++; $display("FAIL race_old got %b want 10", {dv, da}); end
    beat(64'h81, 1'b1, 16'h0A01);
    tests++; if ({dv, da} !== 2'b11) begin fails++; $display("FAIL race_new got %b want 11", {dv, da}); end
    idle();
    tests++; if ({cp, ca, cd} !== {32'd7, 32'd4, 32'd3}) begin
      fails++; $display("FAIL race_cnt got %0d/%0d/%0d want 7/4/3", cp, ca, cd); end
  endtask

  task automatic test_reset_mid();
    wr_rule(3'd0, {1'b1, 1'b0, 64'h0});
    beat(64'h90, 1'b0, 16'h0A01);
    tests++; if ({dv, da} !== 2'b10) begin fails++; $display("FAIL rmid_pre got %b want 10", {dv, da}); end
    beat(64'h91, 1'b0, 16'h0A01);
    s_if.tdata = 64'h92;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (m_if.tvalid !== 1'b0 || m_if.tdata !== 64'h0 || m_if.tuser_src !== 16'h0 || {dv, da} !== 2'b00) begin
      fails++; $display("FAIL rmid_out got v=%b d=%h s=%h dec=%b want 0/0/0/00",
                        m_if.tvalid, m_if.tdata, m_if.tuser_src, {dv, da}); end
    tests++; if ({cp, ca, cd} !== 96'h0) begin fails++; $display("FAIL rmid_cnt got %h want 0", {cp, ca, cd}); end
    s_if.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    beat(64'hA0, 1'b0, 16'h0A01);
    tests++; if ({dv, da} !== 2'b11) begin fails++; $display("FAIL rmid_head got %b want 11", {dv, da}); end
    beat(64'hA1, 1'b1, 16'h0A01);
    tests++; if (dv !== 1'b0 || cp !== 32'd1) begin
      fails++; $display("FAIL rmid_body got %b/%0d want 0/1", dv, cp); end
    idle();
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_rule(3'd3, {1'b1, 1'b1, 16'h0300, 16'hFFFF, 32'h0});
    for (int i = 0; i < 300; i++) beat(64'(i), 1'b1, 16'h0300);
    idle();
    cfg_rd_idx = 3'd3;
    @(negedge clk);
    tests++; if ({cp, ca, cd} !== {32'd300, 32'd300, 32'd0}) begin
      fails++; $display("FAIL b2b_cnt got %0d/%0d/%0d want 300/300/0", cp, ca, cd); end
`ifdef AXIS_RULE_CLASSIFIER_HITCNT_EN
    tests++; if (hits !== 32'd300) begin fails++; $display("FAIL hit_r3 got %0d want 300", hits); end
    cfg_rd_idx = 3'd2;
    @(negedge clk);
    tests++; if (hits !== 32'd0) begin fails++; $display("FAIL hit_r2 got %0d want 0", hits); end
    cfg_rd_idx = 3'd3;
    wr_rule(3'd3, {1'b1, 1'b1, 16'h0300, 16'hFFFF, 32'h0});
    @(negedge clk);
    tests++; if (hits !== 32'd0) begin fails++; $display("FAIL hit_clr got %0d want 0", hits); end
`else
    tests++; if (hits !== 32'd0) begin fails++; $display("FAIL hit_off got %0d want 0", hits); end
`endif
  endtask

  initial begin
    test_reset();
    test_default();
    test_ignored_idx();
    test_rules();
    test_backpressure();
    test_cfg_race();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
